ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Execute->memory pipeline stage consuming ALU result and compare flags. Resolves branches/jumps
//  (BEQ..BGEU, JAL, JALR) and issues a one-cycle PC redirect. Buffers results in a 2-entry skid
//  buffer with valid/ready handshakes on both sides. Sits directly downstream of the ALU.
// PARAMETERS
//  XLEN        32  datapath width
//  REG_ADDR_W  5   destination register index width
// PORTS
//  clk                 in   1           clock, all state on rising edge
//  reset               in   1           asynchronous, active-high
//  flush               in   1           sync kill of all held/pending state (trap from later stage)
//  in_valid            in   1           execute stage presents an instruction
//  in_ready            out  1           stage can accept this cycle
//  alu_result          in   XLEN        ALU result (JALR: rs1+imm)
//  equal               in   1           ALU A==B
//  less_than           in   1           ALU signed A<B
//  less_than_unsigned  in   1           ALU unsigned A<B
//  pc                  in   XLEN        instruction PC
//  imm                 in   XLEN        sign-extended branch/JAL offset
//  funct3              in   3           instruction funct3
//  is_branch           in   1           conditional branch
//  is_jal / is_jalr    in   1 each      unconditional jumps (mutually exclusive with is_branch)
//  rd                  in   REG_ADDR_W  destination register
//  reg_write           in   1           write rd
//  mem_read/mem_write  in   1 each      load/store request
//  store_data          in   XLEN        rs2 value for stores
//  out_valid           out  1           head entry valid to memory stage
//  out_ready           in   1           memory stage accepts head
//  out_result          out  XLEN        alu_result, or pc+4 for JAL/JALR
//  out_store_data      out  XLEN        held store_data
//  out_rd, out_funct3  out  REG_ADDR_W,3 held fields
//  out_reg_write, out_mem_read, out_mem_write  out 1 each  held controls
//  redirect_valid      out  1           one-cycle pulse: fetch must go to redirect_pc
//  redirect_pc         out  XLEN        target PC, bits[1:0] always 00
//  misalign_trap       out  1           one-cycle pulse (see CONFIGURATION); else tied 0
// BEHAVIOUR
//  - Reset: both entries invalid, out_* data 0, out_valid=0, in_ready=1, redirect_valid=0,
//    redirect_pc=0, misalign_trap=0.
//  - Buffer states EMPTY/ONE/FULL. in_ready = (state!=FULL), registered, no comb path from out_ready.
//  - accept = in_valid&in_ready; pop = out_valid&out_ready. EMPTY+accept->ONE; ONE+accept&!pop->FULL;
//    ONE+pop&!accept->EMPTY; ONE+accept&pop->ONE (new head); FULL+pop->ONE (skid moves to head).
//  - Latency in->out: 1 cycle. Order strictly preserved. Head stable while out_valid&!out_ready.
//  - Taken on accept: branch funct3 000 equal, 001 !equal, 100 less_than, 101 !less_than,
//    110 less_than_unsigned, 111 !less_than_unsigned, 010/011 never; is_jal/is_jalr always.
//  - Target: branch/JAL pc+imm (mod 2^XLEN wrap); JALR alu_result with bit0 cleared.
//  - redirect_valid registered: high exactly the cycle after a taken accept, redirect_pc=target.
//    Resolution is at accept, independent of buffer stalls. Not-taken branches: no pulse.
//  - Branches pass with reg_write/mem_* as supplied (decoder drives 0).
//  - flush: next cycle all entries invalid, in_ready=1, redirect_valid=0; same-cycle accept dropped,
//    its redirect suppressed. flush outranks accept and pop.
//  - Asserting reset mid-operation clears everything immediately (async), including pending pulse.
// CONFIGURATION
//  EX_MISALIGN_TRAP_EN defined: taken target with bit1=1 -> misalign_trap pulses instead of
//    redirect_valid (same cycle); entry enqueued with reg_write, mem_read, mem_write forced 0.
//  Not defined: bit1 ignored, redirect_pc[1:0] forced 00, misalign_trap tied 0.
// TESTING
//  1 BEQ pc=0x100 imm=0x20 equal=1 -> next cycle redirect_valid=1 redirect_pc=0x120; out_valid=1.
//  2 BLTU less_than_unsigned=0 -> no redirect; BGE less_than=0 pc=0x10 imm=-8 -> redirect_pc=0x8.
//  3 JALR alu_result=0x2003 pc=0x40 rd=1 -> redirect_pc=0x2000, out_result=0x44, out_rd=1.
//  4 out_ready=0, 3 back-to-back valids -> 2 accepted, in_ready=0; out_ready=1 -> drain in order.
//  5 flush with FULL buffer and concurrent taken accept -> next cycle out_valid=0, in_ready=1, no pulse.
//  6 EX_MISALIGN_TRAP_EN, JAL pc=0 imm=0x6 -> misalign_trap=1, redirect_valid=0, out_reg_write=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute->memory stage: branch/jump resolution with a registered one-cycle redirect and a 2-entry skid buffer.
// Optional feature macro: EX_MISALIGN_TRAP_EN (trap on taken targets with bit1 set instead of redirecting).
module ex_mem_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  equal,
    input  logic                  less_than,
    input  logic                  less_than_unsigned,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       imm,
    input  logic [2:0]            funct3,
    input  logic                  is_branch,
    input  logic                  is_jal,
    input  logic                  is_jalr,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [XLEN-1:0]       store_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [XLEN-1:0]       out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [2:0]            out_funct3,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  misalign_trap
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

    typedef struct packed {
        logic [XLEN-1:0]       result;
        logic [XLEN-1:0]       store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } entry_t;

    buf_state_t state, next_state;
    entry_t     head, skid, new_entry;

    logic            accept, pop;
    logic            branch_cond, taken, misaligned, kill_ctrl;
    logic [XLEN-1:0] target;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Branch condition and target resolve purely from the presented instruction.
    always_comb begin
        branch_cond = 1'b0;
        case (funct3)
            3'b000:  branch_cond = equal;
            3'b001:  branch_cond = ~equal;
            3'b100:  branch_cond = less_than;
            3'b101:  branch_cond = ~less_than;
            3'b110:  branch_cond = less_than_unsigned;
            3'b111:  branch_cond = ~less_than_unsigned;
            default: branch_cond = 1'b0;
        endcase
        taken  = is_jal | is_jalr | (is_branch & branch_cond);
        target = is_jalr ? {alu_result[XLEN-1:1], 1'b0} : pc + imm;
    end

`ifdef EX_MISALIGN_TRAP_EN
    assign misaligned = target[1];
`else
    assign misaligned = 1'b0;
`endif

    assign kill_ctrl = taken & misaligned;

    always_comb begin
        new_entry            = '0;
        new_entry.result     = (is_jal | is_jalr) ? pc + XLEN'(4) : alu_result;
        new_entry.store_data = store_data;
        new_entry.rd         = rd;
        new_entry.funct3     = funct3;
        new_entry.reg_write  = reg_write & ~kill_ctrl;
        new_entry.mem_read   = mem_read & ~kill_ctrl;
        new_entry.mem_write  = mem_write & ~kill_ctrl;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // flush wins over any accept or pop in the same cycle.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) next_state = ONE;
                ONE: begin
                    if (accept && !pop)      next_state = FULL;
                    else if (pop && !accept) next_state = EMPTY;
                end
                FULL:  if (pop) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            skid <= '0;
        end else if (!flush) begin
            case (state)
                EMPTY: if (accept) head <= new_entry;
                ONE: begin
                    if (accept && pop)  head <= new_entry;
                    else if (accept)    skid <= new_entry;
                end
                FULL:  if (pop) head <= skid;
                default: ;
            endcase
        end
    end

    assign out_result     = head.result;
    assign out_store_data = head.store_data;
    assign out_rd         = head.rd;
    assign out_funct3     = head.funct3;
    assign out_reg_write  = head.reg_write;
    assign out_mem_read   = head.mem_read;
    assign out_mem_write  = head.mem_write;

    // redirect_pc only updates on a redirect so fetch sees a stable value afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & taken & ~misaligned & ~flush;
            if (accept && taken && !misaligned && !flush) begin
                redirect_pc <= target & {{(XLEN-2){1'b1}}, 2'b00};
            end
        end
    end

`ifdef EX_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= accept & taken & misaligned & ~flush;
        end
    end
`else
    assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; expected values are hand-computed per scenario.
// Scenarios involving bit1-misaligned targets follow EX_MISALIGN_TRAP_EN when it is defined.
module tb_ex_mem_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready;
    logic [XLEN-1:0] alu_result, pc, imm, store_data;
    logic            equal, less_than, less_than_unsigned;
    logic [2:0]      funct3;
    logic            is_branch, is_jal, is_jalr;
    logic [RW-1:0]   rd;
    logic            reg_write, mem_read, mem_write;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_result, out_store_data;
    logic [RW-1:0]   out_rd;
    logic [2:0]      out_funct3;
    logic            out_reg_write, out_mem_read, out_mem_write;
    logic            redirect_valid, misalign_trap;
    logic [XLEN-1:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .equal(equal), .less_than(less_than),
        .less_than_unsigned(less_than_unsigned), .pc(pc), .imm(imm),
        .funct3(funct3), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .store_data(store_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_store_data(out_store_data), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_trap(misalign_trap)
    );

    task automatic clear_inputs();
        flush = 0; in_valid = 0; alu_result = 0; pc = 0; imm = 0; store_data = 0;
        equal = 0; less_than = 0; less_than_unsigned = 0; funct3 = 0;
        is_branch = 0; is_jal = 0; is_jalr = 0; rd = 0;
        reg_write = 0; mem_read = 0; mem_write = 0; out_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_redirect got=%0b/%h exp=0/0", redirect_valid, redirect_pc); end
        total++; if (misalign_trap !== 1'b0) begin bad++; $display("[TB] FAIL reset_trap got=%0b exp=0", misalign_trap); end
        total++; if (out_result !== 32'h0 || out_rd !== 5'd0 || out_reg_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_data got=%h/%0d/%0b exp=0/0/0", out_result, out_rd, out_reg_write); end
        tick();
        reset = 0;
    endtask

    task automatic test_beq();
        clear_inputs();
        in_valid = 1; is_branch = 1; funct3 = 3'b000; equal = 1;
        pc = 32'h100; imm = 32'h20; alu_result = 32'h55; rd = 0;
        tick();
        clear_inputs();
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin bad++; $display("[TB] FAIL beq_redirect got=%0b/%h exp=1/00000120", redirect_valid, redirect_pc); end
        total++; if (out_valid !== 1'b1 || out_result !== 32'h55) begin bad++; $display("[TB] FAIL beq_out got=%0b/%h exp=1/00000055", out_valid, out_result); end
        tick();
        total++; if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL beq_one_cycle got=%0b/%0b exp=0/0", redirect_valid, out_valid); end
    endtask

    task automatic test_not_taken();
        clear_inputs();
        in_valid = 1; is_branch = 1; funct3 = 3'b110; less_than_unsigned = 0; less_than = 1;
        pc = 32'h80; imm = 32'h40;
        tick();
        clear_inputs();
        total++; if (redirect_valid !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bltu_not_taken got=%0b/%0b exp=0/1", redirect_valid, out_valid); end
        tick();
        in_valid = 1; is_branch = 1; funct3 = 3'b101; less_than = 0;
        pc = 32'h10; imm = 32'hFFFF_FFF8;
        tick();
        clear_inputs();
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8) begin bad++; $display("[TB] FAIL bge_taken got=%0b/%h exp=1/00000008", redirect_valid, redirect_pc); end
        tick();
        in_valid = 1; is_branch = 1; funct3 = 3'b010; equal = 1; less_than = 1; less_than_unsigned = 1;
        pc = 32'h200; imm = 32'h100;
        tick();
        clear_inputs();
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("[TB] FAIL f3_010_never got=%0b exp=0", redirect_valid); end
        tick();
    endtask

    task automatic test_jalr();
        clear_inputs();
        in_valid = 1; is_jalr = 1; alu_result = 32'h2003; pc = 32'h40; rd = 1; reg_write = 1;
        tick();
        clear_inputs();
        total++; if (out_result !== 32'h44 || out_rd !== 5'd1) begin bad++; $display("[TB] FAIL jalr_link got=%h/%0d exp=00000044/1", out_result, out_rd); end
`ifdef EX_MISALIGN_TRAP_EN
        total++; if (misalign_trap !== 1'b1 || redirect_valid !== 1'b0 || out_reg_write !== 1'b0) begin bad++; $display("[TB] FAIL jalr_trap got=%0b/%0b/%0b exp=1/0/0", misalign_trap, redirect_valid, out_reg_write); end
`else
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || out_reg_write !== 1'b1) begin bad++; $display("[TB] FAIL jalr_redirect got=%0b/%h/%0b exp=1/00002000/1", redirect_valid, redirect_pc, out_reg_write); end
`endif
        tick();
    endtask

    task automatic test_jal_misalign();
        clear_inputs();
        in_valid = 1; is_jal = 1; pc = 32'h0; imm = 32'h6; rd = 5; reg_write = 1;
        tick();
        clear_inputs();
        total++; if (out_result !== 32'h4 || out_rd !== 5'd5) begin bad++; $display("[TB] FAIL jal_link got=%h/%0d exp=00000004/5", out_result, out_rd); end
`ifdef EX_MISALIGN_TRAP_EN
        total++; if (misalign_trap !== 1'b1 || redirect_valid !== 1'b0 || out_reg_write !== 1'b0) begin bad++; $display("[TB] FAIL jal_trap got=%0b/%0b/%0b exp=1/0/0", misalign_trap, redirect_valid, out_reg_write); end
`else
        total++; if (misalign_trap !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h4 || out_reg_write !== 1'b1) begin bad++; $display("[TB] FAIL jal_nomask got=%0b/%0b/%h/%0b exp=0/1/00000004/1", misalign_trap, redirect_valid, redirect_pc, out_reg_write); end
`endif
        tick();
        total++; if (misalign_trap !== 1'b0) begin bad++; $display("[TB] FAIL jal_trap_pulse got=%0b exp=0", misalign_trap); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        out_ready = 0; in_valid = 1; alu_result = 32'hA1; rd = 1;
        tick();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 32'hA1) begin bad++; $display("[TB] FAIL b2b_first got=%0b/%0b/%h exp=1/1/000000a1", in_ready, out_valid, out_result); end
        alu_result = 32'hA2; rd = 2;
        tick();
        total++; if (in_ready !== 1'b0 || out_result !== 32'hA1) begin bad++; $display("[TB] FAIL b2b_full got=%0b/%h exp=0/000000a1", in_ready, out_result); end
        alu_result = 32'hA3; rd = 3;
        tick();
        total++; if (in_ready !== 1'b0 || out_result !== 32'hA1 || out_rd !== 5'd1) begin bad++; $display("[TB] FAIL b2b_stall got=%0b/%h/%0d exp=0/000000a1/1", in_ready, out_result, out_rd); end
        clear_inputs();
        tick();
        total++; if (out_valid !== 1'b1 || out_result !== 32'hA2 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_drain got=%0b/%h/%0b exp=1/000000a2/1", out_valid, out_result, in_ready); end
        in_valid = 1; alu_result = 32'hB4; rd = 4;
        tick();
        clear_inputs();
        total++; if (out_valid !== 1'b1 || out_result !== 32'hB4 || out_rd !== 5'd4) begin bad++; $display("[TB] FAIL b2b_swap got=%0b/%h/%0d exp=1/000000b4/4", out_valid, out_result, out_rd); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_empty got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        clear_inputs();
        out_ready = 0; in_valid = 1; alu_result = 32'hC1;
        tick();
        alu_result = 32'hC2;
        tick();
        alu_result = 32'hC3; is_branch = 1; funct3 = 3'b000; equal = 1;
        pc = 32'h200; imm = 32'h10; flush = 1;
        tick();
        clear_inputs();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || redirect_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_full got=%0b/%0b/%0b exp=0/1/0", out_valid, in_ready, redirect_valid); end
        out_ready = 0; in_valid = 1; alu_result = 32'hD1;
        tick();
        alu_result = 32'hD2; is_branch = 1; funct3 = 3'b001; equal = 0;
        pc = 32'h300; imm = 32'h20; flush = 1;
        tick();
        clear_inputs();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || redirect_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_accept got=%0b/%0b/%0b exp=0/1/0", out_valid, in_ready, redirect_valid); end
        tick();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        out_ready = 0; in_valid = 1; is_branch = 1; funct3 = 3'b000; equal = 1;
        pc = 32'h300; imm = 32'h4;
        tick();
        clear_inputs();
        out_ready = 0;
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin bad++; $display("[TB] FAIL pre_reset_redirect got=%0b/%h exp=1/00000304", redirect_valid, redirect_pc); end
        #2 reset = 1;
        #1;
        total++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL async_reset got=%0b/%h/%0b/%0b exp=0/0/0/1", redirect_valid, redirect_pc, out_valid, in_ready); end
        tick();
        reset = 0;
        tick();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_beq();
        test_not_taken();
        test_jalr();
        test_jal_misalign();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
